// File: rtl/alu_div_seq.sv
// Sequential restoring divider for DIV/IDIV (64/32 -> 32q, 32r) with #DE fault detection.
// Define DIV_SIGNED_EN to build IDIV support; without it every request is unsigned.
module alu_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_dvd_hi,
  input  logic [31:0] req_dvd_lo,
  input  logic [31:0] req_dvs,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quot,
  output logic [31:0] out_rem,
  output logic        out_fault,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] dvd_hi_r, dvd_lo_r, dvs_r;
  logic [DATA_W-1:0] rem_r, dq_r;
  logic [4:0]        cnt_r;

  logic [2*DATA_W-1:0] mag_dvd;
  logic [DATA_W-1:0]   mag_dvs;
  logic                prep_fault;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   fix_quot, fix_rem;
  logic                fix_ovf;

`ifdef DIV_SIGNED_EN
  logic sgn_r, neg_q_r, neg_r_r;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*DATA_W-1:0] abs_dw(input logic [2*DATA_W-1:0] v);
    return v[2*DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Signed quotient range is [-2^31, 2^31-1]; check the magnitude before negation.
  function automatic logic quot_ovf(input logic [DATA_W-1:0] q, input logic neg);
    return neg ? (q > 32'h8000_0000) : (q > 32'h7FFF_FFFF);
  endfunction

  always_comb begin
    if (sgn_r) begin
      mag_dvd = abs_dw({dvd_hi_r, dvd_lo_r});
      mag_dvs = dvs_r[DATA_W-1] ? neg_w(dvs_r) : dvs_r;
    end else begin
      mag_dvd = {dvd_hi_r, dvd_lo_r};
      mag_dvs = dvs_r;
    end
  end

  always_comb begin
    fix_ovf  = sgn_r & quot_ovf(dq_r, neg_q_r);
    fix_quot = neg_q_r ? neg_w(dq_r) : dq_r;
    fix_rem  = neg_r_r ? neg_w(rem_r) : rem_r;
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid && !flush)
      sgn_r <= req_signed;
    if (state == S_PREP) begin
      neg_q_r <= sgn_r & (dvd_hi_r[DATA_W-1] ^ dvs_r[DATA_W-1]);
      neg_r_r <= sgn_r & dvd_hi_r[DATA_W-1];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = req_signed;

  always_comb begin
    mag_dvd  = {dvd_hi_r, dvd_lo_r};
    mag_dvs  = dvs_r;
    fix_ovf  = 1'b0;
    fix_quot = dq_r;
    fix_rem  = rem_r;
  end
`endif

  // Zero divisor, or a high half that already exceeds the divisor, cannot yield a 32-bit quotient.
  assign prep_fault = (mag_dvs == '0) | (mag_dvd[2*DATA_W-1:DATA_W] >= mag_dvs);
  assign trial      = {rem_r, dq_r[DATA_W-1]} - {1'b0, dvs_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req_valid) state_nxt = S_PREP;
        S_PREP:  state_nxt = prep_fault ? S_DONE : S_RUN;
        S_RUN:   if (cnt_r == 5'd0) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  // dq_r shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          dvd_hi_r <= req_dvd_hi;
          dvd_lo_r <= req_dvd_lo;
          dvs_r    <= req_dvs;
        end
      end
      S_PREP: begin
        rem_r <= mag_dvd[2*DATA_W-1:DATA_W];
        dq_r  <= mag_dvd[DATA_W-1:0];
        dvs_r <= mag_dvs;
        cnt_r <= 5'd31;
      end
      S_RUN: begin
        rem_r <= trial[DATA_W] ? {rem_r[DATA_W-2:0], dq_r[DATA_W-1]} : trial[DATA_W-1:0];
        dq_r  <= {dq_r[DATA_W-2:0], ~trial[DATA_W]};
        cnt_r <= cnt_r - 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_quot  <= '0;
      out_rem   <= '0;
      out_fault <= 1'b0;
    end else if (flush) begin
      out_fault <= 1'b0;
    end else begin
      case (state)
        S_PREP: begin
          if (prep_fault) begin
            out_quot  <= '0;
            out_rem   <= '0;
            out_fault <= 1'b1;
          end
        end
        S_FIX: begin
          out_quot  <= fix_ovf ? '0 : fix_quot;
          out_rem   <= fix_ovf ? '0 : fix_rem;
          out_fault <= fix_ovf;
        end
        S_DONE: if (out_ready) out_fault <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_div_seq.md
# alu_div_seq

Multi-cycle divide sequencer for the execute stage's ALU_OP_DIV path (DIV/IDIV, 32-bit operand size). It accepts an EDX:EAX dividend and a 32-bit divisor over a valid/ready request port, runs a restoring shift-subtract loop one quotient bit per cycle, and returns quotient (EAX), remainder (EDX) and a #DE fault flag over a valid/ready result port. Execute stalls on `busy` while a division is in flight.

## Interface
Parameters: none.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: division request valid.
- `req_ready` out 1: block is IDLE and can accept a request.
- `req_signed` in 1: 1 = IDIV, 0 = DIV.
- `req_dvd_hi` in 32: dividend high word (EDX).
- `req_dvd_lo` in 32: dividend low word (EAX).
- `req_dvs` in 32: divisor.
- `flush` in 1: synchronous abort; returns the block to IDLE.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_quot` out 32: quotient.
- `out_rem` out 32: remainder.
- `out_fault` out 1: divide error (#DE) from a zero divisor or quotient overflow.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE. Reset state is IDLE. All outputs reset to 0 except `req_ready`, which resets to 1.
- IDLE: `req_ready`=1. On `req_valid`, capture all operands and go to PREP.
- PREP:
  - If signed, take two's-complement magnitudes of the 64-bit dividend and of the divisor. Record `neg_q` = sign(dvd) XOR sign(dvs) and `neg_r` = sign(dvd).
  - Fault when |dvs|==0, or when |dvd_hi| >= |dvs| (the unsigned quotient cannot fit in 32 bits). On fault: set `out_quot`=0, `out_rem`=0, `out_fault`=1, and go to DONE.
  - Otherwise load the partial remainder from |dvd_hi|, set the bit counter to 31, and go to RUN.
- RUN, once per cycle:
  - Form the 33-bit trial value {rem, next dividend bit} − {0, dvs}.
  - If the trial is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - The counter decrements. After the iteration at counter==0, go to FIX. RUN takes exactly 32 cycles.
- FIX:
  - If signed, negate the quotient when `neg_q` and the remainder when `neg_r`.
  - Signed overflow: fault if |q| > 0x7FFFFFFF with `neg_q`=0, or |q| > 0x80000000 with `neg_q`=1. On fault, zero both results and set `out_fault`.
  - Register results and go to DONE.
- DONE: `out_valid`=1. `out_quot`, `out_rem` and `out_fault` stay stable until `out_ready`. On `out_valid & out_ready`, go to IDLE and clear `out_valid` and `out_fault`. The result registers keep their last value.
- `flush` in any state: go to IDLE next edge, clear `out_valid` and `out_fault`, and drop any pending result. A request presented together with `flush` is not accepted.
- Asynchronous reset mid-operation: immediate return to IDLE with reset output values. No partial result is ever presented.

## Timing
- Request accepted at edge E0 (`req_valid & req_ready`).
- Normal path:
  - PREP decides at E1.
  - RUN iterates at E2..E33.
  - FIX at E34.
  - `out_valid` is high starting the cycle after E34, i.e. 34 cycles after acceptance.
- Fault detected in PREP: `out_valid` high the cycle after E1 (latency 1).
- Fault detected in FIX (signed overflow): same latency as the normal path, 34.
- Back-to-back: the earliest next acceptance is the edge after the result handshake, because `req_ready` is low in DONE.
- `busy` = !`req_ready`. Both are registered state decodes with no combinational path from inputs.

## Configuration
- `DIV_SIGNED_EN` defined: IDIV is supported as described.
- `DIV_SIGNED_EN` undefined:
  - `req_signed` is ignored and every request is treated as unsigned.
  - The magnitude/negate logic and the FIX overflow check are removed.
  - FIX still exists as a single register stage, so latency is 34 in both builds.

## Test plan
- Unsigned 0:100 / 7 → `out_quot`=14, `out_rem`=2, `out_fault`=0, `out_valid` exactly 34 cycles after acceptance.
- Divisor 0 (any dividend) → `out_fault`=1, quot/rem=0, latency 1. Also unsigned hi=5, lo=0, dvs=5 → fault (overflow).
- Signed 0xFFFFFFFF:0xFFFFFFF9 (−7) / 2 → quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 0xFFFFFFFF:0x80000000 / 0xFFFFFFFF → fault at latency 34.
- Hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `req_ready`=0, and a new `req_valid` is ignored. Raise `out_ready` → IDLE next edge and the next request is accepted.
- Assert `flush` at RUN cycle 15 → IDLE next edge, no `out_valid`. A following 0:9 / 3 request completes with quot=3, rem=0.
- Drop `rst_n` mid-RUN → `out_valid`=0 and `req_ready`=1 asynchronously. After release, a new division completes correctly.
